mcu_wb_probe_monitor: RTL and testbench
=======================================

Name: mcu_wb_probe_monitor

Overview:
Parametrised Wishbone slave for the user-project wrapper. It captures N_CH probe channels from the MCU-32X core (result, address, strobes, etc.) into snapshot registers and flags per-channel changes. It raises a maskable interrupt on change, counts samples, and supports configurable wait states. Software can read and control the block, replacing fixed read-only monitoring.

Parameters:
N_CH, 4, number of probe channels (1..16)
CH_W, 8, bits per channel (1..32); channel values are zero-extended to 32 bits on read
WAIT_STATES, 0, extra cycles before ack (0..3)

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  synchronous reset, active-high
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte lane selects
wbs_dat_i  in  32  write data
wbs_adr_i  in  32  address; only [7:2] decoded
wbs_ack_o  out  1  one-cycle acknowledge
wbs_dat_o  out  32  read data; valid only while ack=1, otherwise 0
probe_i  in  N_CH*CH_W  channel i occupies bits [i*CH_W +: CH_W]
irq_o  out  1  registered interrupt, level

Behaviour:
- One clock, wb_clk_i. Reset is synchronous, active-high on wb_rst_i. On reset, all registers, outputs, FSM and counters are 0.
- Register map (byte offsets):
  - 0x00 CTRL rw: bit0 EN, bit1 FREEZE, bit2 IRQ_EN; other bits read 0.
  - 0x04 STATUS: [N_CH-1:0] changed flags, write-1-to-clear.
  - 0x08 MASK rw: [N_CH-1:0].
  - 0x0C SAMPLE_CNT ro: any write clears it to 0.
  - 0x10 ID ro: {8'h32, 8'h58, N_CH[7:0], CH_W[7:0]}.
  - 0x40+4*i CH[i] ro: snapshot of channel i.
  - Unmapped offsets, and CH[i] with i>=N_CH, read 0. Writes to them are ignored but still acked.
- Byte lanes: writes to CTRL, MASK and STATUS honour wbs_sel_i per byte.
- Sampling: when EN=1 and FREEZE=0, each cycle
  - cap[i] <= probe slice;
  - changed[i] sets if probe slice != cap[i] (compared against the old cap);
  - SAMPLE_CNT increments and wraps 0xFFFFFFFF -> 0.
  Otherwise cap, changed and SAMPLE_CNT hold.
- Collisions:
  - Change-set and W1C on the same flag in the same cycle: set wins.
  - SAMPLE_CNT clear and increment in the same cycle: result is 0.
- irq_o is registered: irq_o <= IRQ_EN & |(changed & MASK). It is visible one cycle after the flag is set.
- Bus FSM:
  - IDLE: stb&cyc -> WAIT if WAIT_STATES>0, else -> ACK. Address, we, sel and data are latched on entry.
  - WAIT: counts WAIT_STATES cycles, then -> ACK. If cyc=0 during WAIT -> IDLE with no ack and no write.
  - ACK: ack=1 for exactly one cycle. The write commits in this cycle. Read data is taken from register state at the end of the last WAIT cycle, or at the request cycle when WAIT_STATES=0. Next state is always IDLE.
  - A held stb starts a new transaction from IDLE, so there are no back-to-back acks. Minimum spacing is 2 cycles.
- Latency: ack is asserted WAIT_STATES+1 cycles after the cycle in which stb&cyc is first sampled in IDLE.
- Reset mid-transaction: FSM -> IDLE, no ack, and any pending write is dropped.
- A CTRL write takes effect on sampling from the cycle after ACK.

Test Plan:
- Reset, then read ID with default parameters -> dat=0x32580408. Ack is high exactly 1 cycle, on the cycle after stb&cyc. All other registers read 0; irq_o=0.
- Write CTRL=0x5, MASK=0x2. Drive channel1 0x00 -> 0xA5 -> STATUS=0x2, irq_o=1 one cycle after the flag sets, CH[1]=0x000000A5. W1C write STATUS=0x2 with the probe stable -> STATUS=0, irq_o=0.
- FREEZE=1 with the probe toggling every cycle -> CH[] and SAMPLE_CNT unchanged and no new flags. Clear FREEZE -> counting resumes from the held value.
- Collision: W1C STATUS bit0 in the same cycle channel0 changes -> bit0 reads 1 afterwards.
- WAIT_STATES=2: ack on the 3rd cycle after request. A second instance with cyc dropped after 1 cycle gets no ack, and a write to MASK of 0xF is not applied.
- Write SAMPLE_CNT while EN=1 -> reads 0 next access, then increments. Assert reset mid-WAIT -> no ack, all registers 0.

Source files
------------

// File: rtl/mcu_wb_probe_monitor.sv
// Wishbone-accessible probe monitor: snapshots N_CH probe channels, flags changes,
// counts samples and raises a maskable level interrupt.
module mcu_wb_probe_monitor #(
    parameter int N_CH        = 4,
    parameter int CH_W        = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_dat_i,
    input  logic [31:0]          wbs_adr_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    input  logic [N_CH*CH_W-1:0] probe_i,
    output logic                 irq_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    localparam logic [1:0] WS_LAST = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    state_t            state_q, state_d;
    logic [1:0]        wcnt_q, wcnt_d;
    logic [5:0]        adr_q, adr_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       dat_q, dat_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [N_CH-1:0]   changed_q, changed_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              irq_q;
    logic [CH_W-1:0]   cap_q [N_CH];

    logic [5:0]        rd_adr;
    logic [31:0]       rd_mux;
    logic              wr_en;
    logic              active;
    logic [N_CH-1:0]   byte_n;
    logic [N_CH-1:0]   wd_n;
    logic [N_CH-1:0]   w1c;
    logic [N_CH-1:0]   set_vec;
    logic              unused_bits;

    assign unused_bits = ^{wbs_adr_i[31:8], wbs_adr_i[1:0], dat_q, sel_q};

    // In IDLE the read mux looks at the live address so a zero-wait read sees request-cycle state.
    assign rd_adr = (state_q == S_IDLE) ? wbs_adr_i[7:2] : adr_q;

    always_comb begin
        rd_mux = '0;
        case (rd_adr)
            6'h00:   rd_mux[2:0]      = ctrl_q;
            6'h01:   rd_mux[N_CH-1:0] = changed_q;
            6'h02:   rd_mux[N_CH-1:0] = mask_q;
            6'h03:   rd_mux           = cnt_q;
            6'h04:   rd_mux           = {8'h32, 8'h58, 8'(N_CH), 8'(CH_W)};
            default: ;
        endcase
        for (int i = 0; i < N_CH; i++) begin
            if (rd_adr == 6'(16 + i)) rd_mux[CH_W-1:0] = cap_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        adr_d   = adr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (wbs_stb_i && wbs_cyc_i) begin
                    adr_d = wbs_adr_i[7:2];
                    we_d  = wbs_we_i;
                    sel_d = wbs_sel_i;
                    dat_d = wbs_dat_i;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        wcnt_d  = 2'd0;
                    end else begin
                        state_d = S_ACK;
                        rdata_d = rd_mux;
                    end
                end
            end
            S_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                end else if (wcnt_q == WS_LAST) begin
                    state_d = S_ACK;
                    rdata_d = rd_mux;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_en  = (state_q == S_ACK) && we_q;
    assign active = ctrl_q[0] && !ctrl_q[1];

    always_comb begin
        ctrl_d = ctrl_q;
        mask_d = mask_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < N_CH; i++) begin
            byte_n[i]  = sel_q[i / 8];
            set_vec[i] = active && (probe_i[i*CH_W +: CH_W] != cap_q[i]);
        end
        wd_n = dat_q[N_CH-1:0] & byte_n;
        w1c  = (wr_en && adr_q == 6'h01) ? wd_n : '0;
        // OR-ing the set term last makes a same-cycle change win over the clear.
        changed_d = (changed_q & ~w1c) | set_vec;
        if (wr_en && adr_q == 6'h00 && sel_q[0]) ctrl_d = dat_q[2:0];
        if (wr_en && adr_q == 6'h02) mask_d = (mask_q & ~byte_n) | wd_n;
        if (wr_en && adr_q == 6'h03) begin
            cnt_d = '0;
        end else if (active) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            adr_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            dat_q     <= '0;
            rdata_q   <= '0;
            ctrl_q    <= '0;
            changed_q <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            irq_q     <= 1'b0;
            for (int i = 0; i < N_CH; i++) cap_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            adr_q     <= adr_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            dat_q     <= dat_d;
            rdata_q   <= rdata_d;
            ctrl_q    <= ctrl_d;
            changed_q <= changed_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            irq_q     <= ctrl_q[2] && |(changed_q & mask_q);
            if (active) begin
                for (int i = 0; i < N_CH; i++) cap_q[i] <= probe_i[i*CH_W +: CH_W];
            end
        end
    end

    assign wbs_ack_o = (state_q == S_ACK);
    assign wbs_dat_o = wbs_ack_o ? rdata_q : 32'h0;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_mcu_wb_probe_monitor.sv
// Bench for mcu_wb_probe_monitor: a zero-wait and a two-wait instance, driver tasks,
// per-instance expected-response queues drained by ack monitors.
module tb_mcu_wb_probe_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst, stb, cyc, we;
    logic [3:0]  sel [2];
    logic [31:0] adr [2];
    logic [31:0] dw  [2];
    logic        ack0, ack1, irq0, irq1;
    logic [31:0] dr0, dr1;
    logic [31:0] probe0, probe1;

    mcu_wb_probe_monitor #(.N_CH(4), .CH_W(8), .WAIT_STATES(0)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst[0]), .wbs_stb_i(stb[0]), .wbs_cyc_i(cyc[0]),
        .wbs_we_i(we[0]), .wbs_sel_i(sel[0]), .wbs_dat_i(dw[0]), .wbs_adr_i(adr[0]),
        .wbs_ack_o(ack0), .wbs_dat_o(dr0), .probe_i(probe0), .irq_o(irq0)
    );

    mcu_wb_probe_monitor #(.N_CH(4), .CH_W(8), .WAIT_STATES(2)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst[1]), .wbs_stb_i(stb[1]), .wbs_cyc_i(cyc[1]),
        .wbs_we_i(we[1]), .wbs_sel_i(sel[1]), .wbs_dat_i(dw[1]), .wbs_adr_i(adr[1]),
        .wbs_ack_o(ack1), .wbs_dat_o(dr1), .probe_i(probe1), .irq_o(irq1)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [32:0] exp0_q[$];
    logic [32:0] exp1_q[$];
    logic [32:0] e0, e1;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    endtask

    task automatic check1(input string name, input logic act, input logic expv);
        check(name, {31'b0, act}, {31'b0, expv});
    endtask

    // Bit 32 of a queue entry marks a read whose data must be compared.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ack0 === 1'b1) begin
                check1("dut0_ack_has_request", exp0_q.size() > 0, 1'b1);
                if (exp0_q.size() > 0) begin
                    e0 = exp0_q.pop_front();
                    if (e0[32]) check("dut0_rdata", dr0, e0[31:0]);
                end
            end else begin
                check("dut0_idle_dat", dr0, 32'h0);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (ack1 === 1'b1) begin
                check1("dut1_ack_has_request", exp1_q.size() > 0, 1'b1);
                if (exp1_q.size() > 0) begin
                    e1 = exp1_q.pop_front();
                    if (e1[32]) check("dut1_rdata", dr1, e1[31:0]);
                end
            end else begin
                check("dut1_idle_dat", dr1, 32'h0);
            end
        end
    end

    task automatic xfer(input int d, input logic we_v, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] s, input logic [31:0] expv);
        int lat;
        bit got;
        if (d == 0) exp0_q.push_back({~we_v, expv});
        else        exp1_q.push_back({~we_v, expv});
        stb[d] = 1'b1; cyc[d] = 1'b1; we[d] = we_v; adr[d] = a; dw[d] = wd; sel[d] = s;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if ((d == 0) ? ack0 : ack1) got = 1'b1;
        end
        stb[d] = 1'b0; cyc[d] = 1'b0; we[d] = 1'b0;
        check("ack_latency", 32'(lat), (d == 0) ? 32'd1 : 32'd3);
        @(negedge clk);
        check1("ack_one_cycle", (d == 0) ? ack0 : ack1, 1'b0);
    endtask

    task automatic rd(input int d, input logic [31:0] a, input logic [31:0] expv);
        xfer(d, 1'b0, a, 32'h0, 4'hF, expv);
    endtask

    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
        xfer(d, 1'b1, a, wd, s, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        rst = 2'b11; stb = '0; cyc = '0; we = '0;
        for (int i = 0; i < 2; i++) begin
            sel[i] = '0; adr[i] = '0; dw[i] = '0;
        end
        probe0 = '0; probe1 = '0;
        repeat (3) @(negedge clk);
        rst = 2'b00;
        mon_en = 1'b1;
        check1("rst_ack0", ack0, 1'b0);
        check1("rst_irq0", irq0, 1'b0);
        check1("rst_ack1", ack1, 1'b0);
        check1("rst_irq1", irq1, 1'b0);

        // Register map after reset, including aliasing above bit 7 and out-of-range channels
        rd(0, 32'h10, 32'h3258_0408);
        rd(0, 32'h110, 32'h3258_0408);
        rd(0, 32'h00, 32'h0);
        rd(0, 32'h04, 32'h0);
        rd(0, 32'h08, 32'h0);
        rd(0, 32'h0C, 32'h0);
        for (int i = 0; i < 4; i++) rd(0, 32'h40 + 32'(4 * i), 32'h0);
        rd(0, 32'h14, 32'h0);
        rd(0, 32'h50, 32'h0);
        rd(0, 32'hFC, 32'h0);

        // Change detection and interrupt on channel 1
        wr(0, 32'h08, 32'h2, 4'hF);
        wr(0, 32'h00, 32'h5, 4'hF);
        probe0[15:8] = 8'hA5;
        @(negedge clk);
        check1("irq_not_before_flag", irq0, 1'b0);
        @(negedge clk);
        check1("irq_after_flag", irq0, 1'b1);
        rd(0, 32'h04, 32'h2);
        rd(0, 32'h44, 32'hA5);
        rd(0, 32'h40, 32'h0);
        rd(0, 32'h08, 32'h2);
        rd(0, 32'h00, 32'h5);
        wr(0, 32'h04, 32'h2, 4'hF);
        rd(0, 32'h04, 32'h0);
        check1("irq_cleared", irq0, 1'b0);

        // Sample counter: clear collides with increment, then counting resumes
        wr(0, 32'h0C, 32'hDEAD_BEEF, 4'hF);
        rd(0, 32'h0C, 32'd0);
        rd(0, 32'h0C, 32'd2);
        wr(0, 32'h00, 32'h7, 4'hF);
        for (int i = 0; i < 8; i++) begin
            probe0[7:0]  = 8'(i + 1);
            probe0[15:8] = ~probe0[15:8];
            @(negedge clk);
        end
        probe0 = 32'h0000_A500;
        rd(0, 32'h0C, 32'd6);
        rd(0, 32'h40, 32'h0);
        rd(0, 32'h44, 32'hA5);
        rd(0, 32'h04, 32'h0);
        wr(0, 32'h00, 32'h5, 4'hF);
        rd(0, 32'h0C, 32'd6);
        rd(0, 32'h0C, 32'd8);

        // Flag set and W1C land in the same cycle on channel 0
        probe0[7:0] = 8'h11;
        repeat (2) @(negedge clk);
        rd(0, 32'h04, 32'h1);
        fork
            wr(0, 32'h04, 32'h1, 4'hF);
            begin
                @(posedge clk);
                #1 probe0[7:0] = 8'h22;
            end
        join
        rd(0, 32'h04, 32'h1);
        rd(0, 32'h40, 32'h22);
        check1("irq_masked_ch0", irq0, 1'b0);
        wr(0, 32'h04, 32'h1, 4'hF);
        rd(0, 32'h04, 32'h0);

        // Two-wait-state instance: latency, byte lanes, abort and reset mid-wait
        rd(1, 32'h10, 32'h3258_0408);
        wr(1, 32'h08, 32'h3, 4'hF);
        wr(1, 32'h08, 32'hF, 4'b0010);
        rd(1, 32'h08, 32'h3);
        wr(1, 32'h00, 32'h7, 4'h0);
        rd(1, 32'h00, 32'h0);

        sel[1] = 4'hF; adr[1] = 32'h08; dw[1] = 32'hF; we[1] = 1'b1; stb[1] = 1'b1; cyc[1] = 1'b1;
        @(negedge clk);
        stb[1] = 1'b0; cyc[1] = 1'b0; we[1] = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack1) seen = 1'b1;
        end
        check1("abort_no_ack", seen, 1'b0);
        rd(1, 32'h08, 32'h3);

        wr(1, 32'h00, 32'h1, 4'hF);
        repeat (4) @(negedge clk);
        sel[1] = 4'hF; adr[1] = 32'h08; dw[1] = 32'hC; we[1] = 1'b1; stb[1] = 1'b1; cyc[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b1; stb[1] = 1'b0; cyc[1] = 1'b0; we[1] = 1'b0;
        seen = 1'b0;
        @(negedge clk);
        if (ack1) seen = 1'b1;
        rst[1] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ack1) seen = 1'b1;
        end
        check1("reset_mid_wait_no_ack", seen, 1'b0);
        rd(1, 32'h08, 32'h0);
        rd(1, 32'h00, 32'h0);
        rd(1, 32'h0C, 32'h0);
        rd(1, 32'h04, 32'h0);
        check1("dut1_irq_after_reset", irq1, 1'b0);

        repeat (4) @(negedge clk);
        check("dut0_queue_drained", 32'(exp0_q.size()), 32'd0);
        check("dut1_queue_drained", 32'(exp1_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
